bdc4_countdown: RTL

- Loadable down-counter timer; counterpart of the team's free-running 4-bit up counter (bC4).
- Counts a programmed value down to zero on qualified ticks, then signals completion.
- Used as a delay/timeout generator beside bC4-style counters in the same clock domain.
- Small FSM (IDLE/RUN/PAUSED) with one-cycle done pulse.

---
 rtl/bdc4_pkg.sv | 5 +
 rtl/bdc4_dec_core.sv | 30 +++
 rtl/bdc4_countdown.sv | 71 +++++++
 3 files changed

// File: rtl/bdc4_pkg.sv
// bdc4_pkg: shared state encoding and default width for the bdc4 countdown timer
package bdc4_pkg;
  localparam int BDC4_WIDTH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;
endpackage

// File: rtl/bdc4_dec_core.sv
// bdc4_dec_core: loadable down-count register with reload copy, never goes below zero
module bdc4_dec_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             reload,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);
  logic [WIDTH-1:0] rld;
  assign is_one = q == WIDTH'(1);
  // load beats reload beats decrement; a zero count is held rather than wrapped
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      rld <= '0;
    end else if (load) begin
      q   <= load_val;
      rld <= load_val;
    end else if (reload) begin
      q <= rld;
    end else if (dec && q != '0) begin
      q <= q - WIDTH'(1);
    end
  end
endmodule

// File: rtl/bdc4_countdown.sv
// bdc4_countdown: loadable down-counter timer with one-cycle done pulse; BDC4_AUTO_RELOAD_EN makes it periodic
module bdc4_countdown
  import bdc4_pkg::*;
#(
  parameter int WIDTH = BDC4_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             tick,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done
);
`ifdef BDC4_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  state_t state;
  logic   is_one;
  logic   fire;
  assign fire = !load && state == RUN && !pause && tick;
  bdc4_dec_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (fire),
    .reload   (fire && is_one && AUTO),
    .q        (Q),
    .is_one   (is_one)
  );
  // control FSM: load aborts silently, terminal tick pulses done on the same edge Q hits terminal
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            done  <= Q == '0;
            state <= Q == '0 ? IDLE : RUN;
            busy  <= Q != '0;
          end
          RUN: if (pause) begin
            state <= PAUSED;
          end else if (tick && is_one) begin
            done  <= 1'b1;
            state <= AUTO ? RUN : IDLE;
            busy  <= AUTO;
          end
          PAUSED: if (start) state <= RUN;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
